locker_seq_ctrl: RTL and testbench
==================================

# locker_seq_ctrl

Sequencing controller for the two-button combination locker. It collects button presses into a code word and compares that word against a programmable code. It manages the unlock hold window, counts failed attempts and enforces a lockout period with an alarm. It sits between the raw button inputs and the door actuator, and replaces direct use of the fixed-sequence Moore detector.

## Interface
- CODE_LEN, 5, number of presses per code entry
- RESET_CODE, 5'b01011, code loaded at reset; bit 0 is the first press, and a 1 means button_1
- MAX_FAIL, 3, consecutive mismatches that trigger lockout (≥1)
- UNLOCK_CYCLES, 8, cycles unlock stays high (≥1)
- LOCKOUT_CYCLES, 16, cycles lockout lasts (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- button_0  in  1  press of symbol 0, one cycle per press
- button_1  in  1  press of symbol 1, one cycle per press
- prog_en  in  1  request to load prog_code as the new code
- prog_code  in  CODE_LEN  new code, LSB is the first press
- unlock  out  1  door open
- alarm  out  1  lockout active
- busy  out  1  entry in progress (state ENTRY)
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive mismatches so far

## Operation
- States: IDLE, ENTRY, UNLOCK, LOCKOUT. The shared package holds the state enum.
- Decoding a press:
  - Exactly one button high is a press; the symbol is button_1.
  - Both high is an abort.
  - Neither high means no event.
- IDLE:
  - A press stores the symbol at bit 0, sets idx=1 and moves to ENTRY.
  - An abort does nothing.
- ENTRY:
  - A press stores the symbol at bit idx and increments idx.
  - On the press that makes idx reach CODE_LEN, compare the full word (including that symbol) with the code register:
    - Match: go to UNLOCK, load the timer with UNLOCK_CYCLES, clear fail_cnt.
    - Mismatch: increment fail_cnt. If the new value equals MAX_FAIL, go to LOCKOUT and load the timer with LOCKOUT_CYCLES. Otherwise go to IDLE.
  - An abort clears the partial word and idx, goes to IDLE and leaves fail_cnt unchanged.
- UNLOCK:
  - Presses and aborts are ignored.
  - prog_en=1 loads prog_code into the code register and goes to IDLE immediately (relock).
  - Timer expiry goes to IDLE.
- LOCKOUT:
  - All buttons and prog_en are ignored.
  - On expiry, clear fail_cnt and go to IDLE.
- prog_en outside UNLOCK is ignored; the code register is unchanged.
- Outputs are Moore and registered:
  - unlock = (state==UNLOCK)
  - alarm = (state==LOCKOUT)
  - busy = (state==ENTRY)
- Idle gaps between presses are unlimited. There is no entry timeout.

## Timing
- Reset (rst=0 at a rising edge) sets:
  - state = IDLE
  - code = RESET_CODE
  - fail_cnt = 0, idx = 0, timer = 0
  - unlock, alarm and busy all 0
- Reset mid-entry, mid-unlock or mid-lockout takes effect on that edge, and the code register returns to RESET_CODE.
- Latency: unlock or alarm rises at the edge that samples the final press, so it is visible in the following cycle.
- unlock stays high for exactly UNLOCK_CYCLES cycles, unless prog_en ends it early. In that case unlock is low in the cycle after the edge that samples prog_en.
- alarm stays high for exactly LOCKOUT_CYCLES cycles.
- A press sampled on the edge where the timer expires is ignored, because the state is still UNLOCK or LOCKOUT at that edge.
- fail_cnt saturates at MAX_FAIL and never wraps.

## Structure
- Package locker_pkg holds:
  - the state enum, locker_state_t
  - a symbol-decode helper function
  - the default constants for RESET_CODE, UNLOCK_CYCLES and LOCKOUT_CYCLES
- Sub-module locker_timer: a loadable down-counter.
  - Inputs: load and load_val.
  - Output: a one-cycle `done` when the count reaches 1→0.
  - One instance is shared by UNLOCK and LOCKOUT; its width is $clog2 of the larger cycle count, plus 1.

## Test plan
- Reset, then press button_0/button_1 over 5 cycles giving symbols 1,1,0,1,0 (code 5'b01011) → unlock=1 from the cycle after the 5th press for 8 cycles; fail_cnt=0.
- Enter 5'b00000 three times → fail_cnt goes 1, then 2. On the third entry alarm=1 for 16 cycles, with presses during lockout ignored, then fail_cnt=0.
- Press 3 symbols, then both buttons high → busy=0, fail_cnt unchanged. A subsequent correct 5-press entry unlocks.
- Unlock, then prog_en=1 with prog_code=5'b11100 → unlock drops next cycle. Old code 5'b01011 now fails; 5'b11100 unlocks.
- prog_en=1 with prog_code=5'b11111 while IDLE → ignored; 5'b01011 still unlocks.
- Reset asserted during ENTRY after prog change → code reverts to 5'b01011; all outputs 0 the next cycle.

Source files
------------

// File: rtl/locker_pkg.sv
// ----------------------------------------------------------------------------
// locker_pkg
// Shared definitions for the two-button combination locker.
//   - locker_state_t : sequencing controller states
//   - btn_event_t    : decoded button event (none / press / abort)
//   - decode_buttons : turns the raw button pair into a btn_event_t
//   - DEFAULT_*      : default code, attempt limit and hold-window lengths
// ----------------------------------------------------------------------------
package locker_pkg;

    localparam int         DEFAULT_CODE_LEN       = 5;
    localparam logic [4:0] DEFAULT_RESET_CODE     = 5'b01011;
    localparam int         DEFAULT_MAX_FAIL       = 3;
    localparam int         DEFAULT_UNLOCK_CYCLES  = 8;
    localparam int         DEFAULT_LOCKOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        UNLOCK  = 2'd2,
        LOCKOUT = 2'd3
    } locker_state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_PRESS = 2'd1,
        EV_ABORT = 2'd2
    } btn_event_t;

    // Exactly one button is a press (its symbol is button_1), both together
    // abort the current entry, neither is no event.
    function automatic btn_event_t decode_buttons(input logic b0, input logic b1);
        btn_event_t ev;
        case ({b1, b0})
            2'b01,
            2'b10:   ev = EV_PRESS;
            2'b11:   ev = EV_ABORT;
            default: ev = EV_NONE;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/locker_timer.sv
// ----------------------------------------------------------------------------
// locker_timer
// Loadable down-counter shared by the unlock and lockout windows.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-low reset (count cleared to 0)
//   load     in  load load_val into the counter this edge
//   load_val in  W-bit value to load
//   done     out one-cycle pulse in the cycle whose edge takes the count 1->0
// ----------------------------------------------------------------------------
module locker_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    // Asserted while the count sits at 1, i.e. the coming edge is the expiry
    // edge. The controller leaves its timed state on that same edge, which
    // gives a window of exactly load_val cycles. A reload overrides expiry.
    assign done = !load && (r_count == W'(1));

endmodule

// File: rtl/locker_seq_ctrl.sv
// ----------------------------------------------------------------------------
// locker_seq_ctrl
// Sequencing controller for the two-button combination locker. It collects
// CODE_LEN presses into a word (first press in bit 0) and compares the word
// with a programmable code register. A match opens the door for
// UNLOCK_CYCLES cycles. MAX_FAIL consecutive mismatches raise the alarm for
// LOCKOUT_CYCLES cycles. The code can only be reprogrammed while unlocked,
// and doing so relocks immediately.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-low reset
//   button_0   in  press of symbol 0 (one cycle per press)
//   button_1   in  press of symbol 1 (one cycle per press)
//   prog_en    in  load prog_code as the new code (honoured only in UNLOCK)
//   prog_code  in  new code, LSB is the first press
//   unlock     out door open (registered, state UNLOCK)
//   alarm      out lockout active (registered, state LOCKOUT)
//   busy       out entry in progress (registered, state ENTRY)
//   fail_cnt   out consecutive mismatches, saturating at MAX_FAIL
// CODE_LEN must be at least 2: the first press always lands in ENTRY.
// ----------------------------------------------------------------------------
module locker_seq_ctrl
    import locker_pkg::*;
#(
    parameter int                  CODE_LEN       = DEFAULT_CODE_LEN,
    parameter logic [CODE_LEN-1:0] RESET_CODE     = DEFAULT_RESET_CODE,
    parameter int                  MAX_FAIL       = DEFAULT_MAX_FAIL,
    parameter int                  UNLOCK_CYCLES  = DEFAULT_UNLOCK_CYCLES,
    parameter int                  LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          button_0,
    input  logic                          button_1,
    input  logic                          prog_en,
    input  logic [CODE_LEN-1:0]           prog_code,
    output logic                          unlock,
    output logic                          alarm,
    output logic                          busy,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                 : LOCKOUT_CYCLES;
    localparam int TMR_W  = $clog2(MAX_CYCLES) + 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int IDX_W  = $clog2(CODE_LEN + 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    locker_state_t         r_state;
    logic [CODE_LEN-1:0]   r_code;
    logic [CODE_LEN-1:0]   r_word;
    logic [IDX_W-1:0]      r_idx;
    logic [FAIL_W-1:0]     r_fail;
    logic                  r_unlock;
    logic                  r_alarm;
    logic                  r_busy;

    locker_state_t         w_state_next;
    logic [CODE_LEN-1:0]   w_code_next;
    logic [CODE_LEN-1:0]   w_word_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [FAIL_W-1:0]     w_fail_next;

    logic                  w_tmr_load;
    logic [TMR_W-1:0]      w_tmr_val;
    logic                  w_tmr_done;

    btn_event_t            w_event;
    logic                  w_sym;
    logic [CODE_LEN-1:0]   w_word_ins;
    logic [FAIL_W-1:0]     w_fail_inc;
    logic                  w_last_press;

    assign w_event = decode_buttons(button_0, button_1);
    assign w_sym   = button_1;

    // Partial word with the current symbol dropped into position r_idx. On
    // the final press this is the complete entry used for the comparison.
    genvar gi;
    generate
        for (gi = 0; gi < CODE_LEN; gi++) begin : g_word_ins
            assign w_word_ins[gi] = (r_idx == IDX_W'(gi)) ? w_sym : r_word[gi];
        end
    endgenerate

    assign w_last_press = (r_idx == IDX_W'(CODE_LEN - 1));

    // Saturating increment; lockout normally intercepts at MAX_FAIL anyway.
    assign w_fail_inc = (r_fail == FAIL_W'(MAX_FAIL)) ? r_fail : (r_fail + FAIL_W'(1));

    // ------------------------------------------------------------------
    // Shared unlock / lockout window timer
    // ------------------------------------------------------------------
    locker_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_word_next  = r_word;
        w_idx_next   = r_idx;
        w_fail_next  = r_fail;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;

        case (r_state)
            IDLE: begin
                if (w_event == EV_PRESS) begin
                    w_word_next    = '0;
                    w_word_next[0] = w_sym;
                    w_idx_next     = IDX_W'(1);
                    w_state_next   = ENTRY;
                end
            end

            ENTRY: begin
                if (w_event == EV_PRESS) begin
                    if (w_last_press) begin
                        // Entry complete: the word is consumed either way.
                        w_word_next = '0;
                        w_idx_next  = '0;
                        if (w_word_ins == r_code) begin
                            w_state_next = UNLOCK;
                            w_tmr_load   = 1'b1;
                            w_tmr_val    = TMR_W'(UNLOCK_CYCLES);
                            w_fail_next  = '0;
                        end else begin
                            w_fail_next = w_fail_inc;
                            if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
                                w_state_next = LOCKOUT;
                                w_tmr_load   = 1'b1;
                                w_tmr_val    = TMR_W'(LOCKOUT_CYCLES);
                            end else begin
                                w_state_next = IDLE;
                            end
                        end
                    end else begin
                        w_word_next = w_word_ins;
                        w_idx_next  = r_idx + IDX_W'(1);
                    end
                end else if (w_event == EV_ABORT) begin
                    w_word_next  = '0;
                    w_idx_next   = '0;
                    w_state_next = IDLE;
                end
            end

            UNLOCK: begin
                if (prog_en) begin
                    // Relock on reprogramming; clear the timer so no stale
                    // expiry is left running behind the new state.
                    w_code_next  = prog_code;
                    w_state_next = IDLE;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = '0;
                end else if (w_tmr_done) begin
                    w_state_next = IDLE;
                end
            end

            LOCKOUT: begin
                if (w_tmr_done) begin
                    w_fail_next  = '0;
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers; the Moore outputs are decoded from the next state so they
    // change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_code   <= RESET_CODE;
            r_word   <= '0;
            r_idx    <= '0;
            r_fail   <= '0;
            r_unlock <= 1'b0;
            r_alarm  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_code   <= w_code_next;
            r_word   <= w_word_next;
            r_idx    <= w_idx_next;
            r_fail   <= w_fail_next;
            r_unlock <= (w_state_next == UNLOCK);
            r_alarm  <= (w_state_next == LOCKOUT);
            r_busy   <= (w_state_next == ENTRY);
        end
    end

    assign unlock   = r_unlock;
    assign alarm    = r_alarm;
    assign busy     = r_busy;
    assign fail_cnt = r_fail;

endmodule

// File: tb/tb_locker_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_locker_seq_ctrl
// Directed bench for locker_seq_ctrl with the default parameters
// (code 5'b01011, 3 attempts, 8-cycle unlock, 16-cycle lockout).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_locker_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       button_0;
    logic       button_1;
    logic       prog_en;
    logic [4:0] prog_code;
    logic       unlock;
    logic       alarm;
    logic       busy;
    logic [1:0] fail_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    locker_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .button_0  (button_0),
        .button_1  (button_1),
        .prog_en   (prog_en),
        .prog_code (prog_code),
        .unlock    (unlock),
        .alarm     (alarm),
        .busy      (busy),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic u, input logic a,
                           input logic b, input logic [1:0] f);
        chk({tag, ".unlock"},   {31'd0, unlock},   {31'd0, u});
        chk({tag, ".alarm"},    {31'd0, alarm},    {31'd0, a});
        chk({tag, ".busy"},     {31'd0, busy},     {31'd0, b});
        chk({tag, ".fail_cnt"}, {30'd0, fail_cnt}, {30'd0, f});
    endtask

    // One press held for exactly one rising edge; returns at the falling
    // edge after that rising edge.
    task automatic press(input logic sym);
        @(negedge clk);
        button_0 = ~sym;
        button_1 = sym;
        @(negedge clk);
        button_0 = 1'b0;
        button_1 = 1'b0;
    endtask

    task automatic abort_entry();
        @(negedge clk);
        button_0 = 1'b1;
        button_1 = 1'b1;
        @(negedge clk);
        button_0 = 1'b0;
        button_1 = 1'b0;
    endtask

    // Full entry, first press = bit 0; busy is checked between presses.
    task automatic enter(input string tag, input logic [4:0] code);
        for (int i = 0; i < 5; i++) begin
            press(code[i]);
            if (i < 4) chk({tag, ".busy_mid"}, {31'd0, busy}, 32'd1);
        end
    endtask

    // Called right after the final press: unlock is high for 8 samples,
    // then low.
    task automatic hold_unlock(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, ".unlock_hold"}, {31'd0, unlock}, 32'd1);
            @(negedge clk);
        end
        chk({tag, ".unlock_end"}, {31'd0, unlock}, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        button_0  = 1'b0;
        button_1  = 1'b0;
        prog_en   = 1'b0;
        prog_code = 5'b00000;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b1;

        // Abort while idle does nothing
        abort_entry();
        chk_out("idle_abort", 1'b0, 1'b0, 1'b0, 2'd0);

        // Correct code 1,1,0,1,0 opens for exactly 8 cycles
        enter("good1", 5'b01011);
        chk_out("good1_open", 1'b1, 1'b0, 1'b0, 2'd0);
        hold_unlock("good1");
        $display("txn good1: code 01011 unlocked 8 cycles");

        // prog_en while idle is ignored
        @(negedge clk);
        prog_en   = 1'b1;
        prog_code = 5'b11111;
        @(negedge clk);
        prog_en   = 1'b0;
        chk_out("idle_prog", 1'b0, 1'b0, 1'b0, 2'd0);
        enter("good2", 5'b01011);
        chk_out("good2_open", 1'b1, 1'b0, 1'b0, 2'd0);
        hold_unlock("good2");
        $display("txn idle_prog: prog 11111 ignored, 01011 still unlocks");

        // One wrong entry, then a partial entry aborted, then correct
        enter("bad_a", 5'b00000);
        chk_out("bad_a_done", 1'b0, 1'b0, 1'b0, 2'd1);
        press(1'b1);
        press(1'b1);
        press(1'b0);
        chk_out("partial3", 1'b0, 1'b0, 1'b1, 2'd1);
        abort_entry();
        chk_out("aborted", 1'b0, 1'b0, 1'b0, 2'd1);
        enter("good3", 5'b01011);
        chk_out("good3_open", 1'b1, 1'b0, 1'b0, 2'd0);
        hold_unlock("good3");
        $display("txn abort: fail_cnt held at 1, then correct entry unlocked");

        // Three wrong entries -> lockout for 16 cycles
        enter("bad1", 5'b00000);
        chk_out("bad1_done", 1'b0, 1'b0, 1'b0, 2'd1);
        enter("bad2", 5'b00000);
        chk_out("bad2_done", 1'b0, 1'b0, 1'b0, 2'd2);
        enter("bad3", 5'b00000);
        chk_out("lockout_start", 1'b0, 1'b1, 1'b0, 2'd3);
        for (int k = 0; k < 16; k++) begin
            chk("lockout_hold.alarm", {31'd0, alarm}, 32'd1);
            chk("lockout_hold.busy",  {31'd0, busy},  32'd0);
            // Presses (including one on the expiry edge) and prog_en are ignored
            button_1  = (k % 2 == 0) || (k == 15);
            prog_en   = (k == 3);
            prog_code = 5'b11111;
            @(negedge clk);
        end
        button_1 = 1'b0;
        prog_en  = 1'b0;
        chk_out("lockout_end", 1'b0, 1'b0, 1'b0, 2'd0);
        $display("txn lockout: alarm 16 cycles, presses ignored, fail_cnt cleared");

        // Reprogram while unlocked relocks on the next cycle
        enter("good4", 5'b01011);
        chk_out("good4_open", 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        chk("good4_still_open", {31'd0, unlock}, 32'd1);
        prog_en   = 1'b1;
        prog_code = 5'b11100;
        @(negedge clk);
        prog_en   = 1'b0;
        chk_out("relock", 1'b0, 1'b0, 1'b0, 2'd0);
        enter("old_code", 5'b01011);
        chk_out("old_code_fails", 1'b0, 1'b0, 1'b0, 2'd1);
        enter("new_code", 5'b11100);
        chk_out("new_code_open", 1'b1, 1'b0, 1'b0, 2'd0);
        hold_unlock("new_code");
        $display("txn prog: code changed to 11100, old fails, new unlocks");

        // Reset in the middle of an entry restores the reset code
        enter("bad_b", 5'b00000);
        chk_out("bad_b_done", 1'b0, 1'b0, 1'b0, 2'd1);
        press(1'b1);
        press(1'b1);
        chk_out("pre_reset", 1'b0, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_out("mid_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b1;
        enter("after_reset", 5'b01011);
        chk_out("after_reset_open", 1'b1, 1'b0, 1'b0, 2'd0);
        hold_unlock("after_reset");
        $display("txn reset: code reverted to 01011");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
